// File: rtl/int2flt_seq.sv
// Sequential int16 -> float16 converter: reads a big-endian integer from data memory,
// normalises it one shift per cycle, rounds to nearest-even and writes the float back.
module int2flt_seq #(
  parameter logic [7:0] SRC_ADDR = 8'd0,
  parameter logic [7:0] DST_ADDR = 8'd128
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] mem_rdata,
  output logic [7:0] mem_addr,
  output logic       mem_rd_en,
  output logic       mem_wr_en,
  output logic [7:0] mem_wdata,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    IDLE, RD_HI, RD_LO, ABS, NORM, ROUND, WR_HI, WR_LO
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] data_q, data_d;
  logic [15:0] mag_q, mag_d;
  logic [15:0] res_q, res_d;
  logic [4:0]  exp_q, exp_d;
  logic        sign_q, sign_d;
  logic        done_q, done_d;

  logic        round_up;
  logic [10:0] mant_rnd;

  // Round-to-nearest-even on the bits below the 10-bit mantissa; bit 10 is the carry-out.
  assign round_up = mag_q[4] & ((|mag_q[3:0]) | mag_q[5]);
  assign mant_rnd = {1'b0, mag_q[14:5]} + {10'd0, round_up};

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values of the others, independent of statement order.
    if (reset) begin
      state_q <= IDLE;
      data_q  <= '0;
      mag_q   <= '0;
      res_q   <= '0;
      exp_q   <= '0;
      sign_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      mag_q   <= mag_d;
      res_q   <= res_d;
      exp_q   <= exp_d;
      sign_q  <= sign_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d   = state_q;
    data_d    = data_q;
    mag_d     = mag_q;
    res_d     = res_q;
    exp_d     = exp_q;
    sign_d    = sign_q;
    done_d    = done_q;
    mem_addr  = 8'd0;
    mem_rd_en = 1'b0;
    mem_wr_en = 1'b0;
    mem_wdata = 8'd0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RD_HI;
          done_d  = 1'b0;
        end
      end
      RD_HI: begin
        mem_addr       = SRC_ADDR;
        mem_rd_en      = 1'b1;
        data_d[15:8]   = mem_rdata;
        state_d        = RD_LO;
      end
      RD_LO: begin
        mem_addr       = SRC_ADDR + 8'd1;
        mem_rd_en      = 1'b1;
        data_d[7:0]    = mem_rdata;
        state_d        = ABS;
      end
      ABS: begin
        sign_d = data_q[15];
        mag_d  = data_q[15] ? (~data_q + 16'd1) : data_q;
        exp_d  = 5'd30;
        if (data_q == 16'd0) begin
          res_d   = 16'd0;
          state_d = WR_HI;
        end else begin
          state_d = NORM;
        end
      end
      NORM: begin
        if (mag_q[15]) begin
          state_d = ROUND;
        end else begin
          mag_d = {mag_q[14:0], 1'b0};
          exp_d = exp_q - 5'd1;
        end
      end
      ROUND: begin
        res_d   = {sign_q, exp_q + {4'd0, mant_rnd[10]}, mant_rnd[9:0]};
        state_d = WR_HI;
      end
      WR_HI: begin
        mem_addr  = DST_ADDR;
        mem_wr_en = 1'b1;
        mem_wdata = res_q[15:8];
        state_d   = WR_LO;
      end
      WR_LO: begin
        mem_addr  = DST_ADDR + 8'd1;
        mem_wr_en = 1'b1;
        mem_wdata = res_q[7:0];
        state_d   = IDLE;
        done_d    = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // A reset cycle must not touch memory, even when it lands in a read or write state.
    if (reset) begin
      mem_addr  = 8'd0;
      mem_rd_en = 1'b0;
      mem_wr_en = 1'b0;
      mem_wdata = 8'd0;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;

endmodule

// File: tb/tb_int2flt_seq.sv
// Self-checking bench for int2flt_seq: table of integer/float/latency vectors fed through
// a scoreboard queue, plus hand-written reset and start-while-busy sequences.
module tb_int2flt_seq;

  localparam logic [7:0] SRC = 8'd0;
  localparam logic [7:0] DST = 8'd128;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] mem_rdata;
  logic [7:0] mem_addr;
  logic       mem_rd_en;
  logic       mem_wr_en;
  logic [7:0] mem_wdata;
  logic       busy;
  logic       done;

  int2flt_seq #(.SRC_ADDR(SRC), .DST_ADDR(DST)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .mem_rdata (mem_rdata),
    .mem_addr  (mem_addr),
    .mem_rd_en (mem_rd_en),
    .mem_wr_en (mem_wr_en),
    .mem_wdata (mem_wdata),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Memory model; all writes (DUT or bench preload) happen in this one process.
  logic [7:0]  mem [256];
  logic        preload = 1'b0;
  logic [15:0] pre_word = 16'd0;
  int          wr_cnt = 0;
  int          bad_addr = 0;
  int          overlap = 0;
  int          idle_bus = 0;
  logic [7:0]  wr_log [4];

  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (preload) begin
      mem[SRC]         <= pre_word[15:8];
      mem[SRC + 8'd1]  <= pre_word[7:0];
      mem[DST]         <= 8'hAA;
      mem[DST + 8'd1]  <= 8'h55;
      wr_cnt           <= 0;
    end else if (mem_wr_en) begin
      mem[mem_addr] <= mem_wdata;
      if (wr_cnt < 4) wr_log[wr_cnt] <= mem_addr;
      wr_cnt <= wr_cnt + 1;
      if (mem_addr != DST && mem_addr != DST + 8'd1) bad_addr <= bad_addr + 1;
    end
    if (mem_rd_en && mem_wr_en) overlap <= overlap + 1;
    if (!mem_rd_en && !mem_wr_en && (mem_addr != 8'd0 || mem_wdata != 8'd0))
      idle_bus <= idle_bus + 1;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [15:0] x;
    logic [15:0] res;
    int          lat;
  } vec_t;

  logic [15:0] exp_q [$];

  task automatic load(input logic [15:0] x);
    pre_word = x;
    preload  = 1'b1;
    @(posedge clk);
    #1 preload = 1'b0;
  endtask

  // Samples start on the next edge (edge 0), then counts edges until done rises.
  task automatic kick_and_wait(input string name, output int lat);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check({name, " accept busy"}, {31'd0, busy}, 32'd1);
    check({name, " accept done"}, {31'd0, done}, 32'd0);
    lat = 0;
    while (!done && lat < 40) begin
      @(posedge clk);
      #1 lat++;
    end
  endtask

  task automatic run_conv(input string name, input vec_t v);
    int          lat;
    logic [15:0] want;
    load(v.x);
    exp_q.push_back(v.res);
    kick_and_wait(name, lat);
    check({name, " latency"}, lat, v.lat);
    if (exp_q.size() == 0) begin
      check({name, " scoreboard empty"}, 32'd1, 32'd0);
    end else begin
      want = exp_q.pop_front();
      check({name, " result"}, {16'd0, mem[DST], mem[DST + 8'd1]}, {16'd0, want});
    end
    check({name, " writes"}, wr_cnt, 2);
    check({name, " write order"}, {16'd0, wr_log[0], wr_log[1]}, {16'd0, DST, DST + 8'd1});
    check({name, " idle busy"}, {31'd0, busy}, 32'd0);
  endtask

  vec_t vecs [11];
  int   lat;

  initial begin
    vecs[0]  = '{16'h0001, 16'h3C00, 22};
    vecs[1]  = '{16'hFFFF, 16'hBC00, 22};
    vecs[2]  = '{16'h7FFF, 16'h7800, 8};
    vecs[3]  = '{16'h8000, 16'hF800, 7};
    vecs[4]  = '{16'h0801, 16'h6800, 11};
    vecs[5]  = '{16'h0803, 16'h6802, 11};
    vecs[6]  = '{16'h0000, 16'h0000, 5};
    vecs[7]  = '{16'h0400, 16'h6400, 12};
    vecs[8]  = '{16'hFC00, 16'hE400, 12};
    vecs[9]  = '{16'h0003, 16'h4200, 21};
    vecs[10] = '{16'h1234, 16'h6C8D, 10};

    reset = 1'b1;
    start = 1'b1;  // start during reset must be ignored
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset bus", {14'd0, mem_rd_en, mem_wr_en, mem_addr, mem_wdata}, 32'd0);
    reset = 1'b0;
    start = 1'b0;
    @(posedge clk);
    #1 check("post-reset idle", {30'd0, busy, done}, 32'd0);

    foreach (vecs[i]) run_conv($sformatf("vec%0d", i), vecs[i]);

    // Reset during NORM aborts with no writes; a restart then completes.
    load(16'h0001);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (6) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    check("abort busy/done", {30'd0, busy, done}, 32'd0);
    check("abort dst untouched", {16'd0, mem[DST], mem[DST + 8'd1]}, 32'h0000AA55);
    check("abort writes", wr_cnt, 0);
    run_conv("restart", vecs[0]);

    // Reset landing in WR_LO suppresses the low-byte write.
    load(16'h0000);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    check("wrlo abort writes", wr_cnt, 1);
    check("wrlo abort low byte", {24'd0, mem[DST + 8'd1]}, 32'h55);
    check("wrlo abort done", {31'd0, done}, 32'd0);

    // Start pulsed while busy: exactly one conversion.
    load(16'h0801);
    exp_q.push_back(16'h6800);
    start = 1'b1;
    @(posedge clk);
    lat = 0;
    for (int k = 1; k <= 9; k++) begin
      #1 start = k[0];
      @(posedge clk);
      lat++;
    end
    #1 start = 1'b0;
    while (!done && lat < 40) begin
      @(posedge clk);
      #1 lat++;
    end
    check("busy-start latency", lat, 11);
    repeat (3) @(posedge clk);
    #1;
    check("busy-start writes", wr_cnt, 2);
    check("busy-start idle", {30'd0, busy, done}, 32'd1);
    check("busy-start result", {16'd0, mem[DST], mem[DST + 8'd1]}, {16'd0, exp_q.pop_front()});

    // Start after done: done drops on acceptance, new result written.
    run_conv("after-done", vecs[2]);

    check("bad write addresses", bad_addr, 0);
    check("rd/wr overlap", overlap, 0);
    check("idle bus nonzero", idle_bus, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
